spi_word_rx: RTL and testbench

SPI_WORD_RX -- requirements
Module: spi_word_rx

---
 rtl/spi_word_rx.sv | 185 ++++++++++++++++++
 tb/tb_spi_word_rx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spi_word_rx.sv
// SPI mode-0 word receiver: synchronizes csn/sck/mosi into clk, shifts MSB-first
// frames of WIDTH bits, and flags non-BCD words and frames of the wrong length.
module spi_word_rx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             csn,
  input  logic             sck,
  input  logic             mosi,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             bcd_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ARM   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [SYNC_STAGES-1:0] r_csn_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_csn_d;
  logic                   r_sck_d;
  logic [1:0]             r_arm_cnt;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_shift;
  logic                   r_ovf;
  logic                   r_valid_d;
  logic                   r_ferr_d;

  logic             w_csn_s;
  logic             w_sck_s;
  logic             w_mosi_s;
  logic             w_csn_rise;
  logic             w_csn_fall;
  logic             w_sck_rise;
  logic             w_shift_en;
  logic             w_load;
  logic             w_ferr_evt;
  logic             w_ovf_set;
  logic [WIDTH-1:0] w_shift_nx;

  function automatic logic f_bcd_err(input logic [WIDTH-1:0] w);
    logic e;
    e = 1'b0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      e = e | (w[4*i +: 4] > 4'd9);
    end
    return e;
  endfunction

  assign w_csn_s    = r_csn_sync[SYNC_STAGES-1];
  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_csn_rise = w_csn_s & ~r_csn_d;
  assign w_csn_fall = ~w_csn_s & r_csn_d;
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_shift_nx = {r_shift[WIDTH-2:0], w_mosi_s};
  assign busy       = (r_state == ST_SHIFT) || (r_state == ST_HOLD);

  // State register, synchronizers, datapath and output pulse pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_ARM;
      r_csn_sync  <= {SYNC_STAGES{1'b1}};
      r_sck_sync  <= {SYNC_STAGES{1'b0}};
      r_mosi_sync <= {SYNC_STAGES{1'b0}};
      r_csn_d     <= 1'b1;
      r_sck_d     <= 1'b0;
      r_arm_cnt   <= 2'd0;
      r_cnt       <= {CW{1'b0}};
      r_shift     <= {WIDTH{1'b0}};
      r_ovf       <= 1'b0;
      r_valid_d   <= 1'b0;
      r_ferr_d    <= 1'b0;
      data        <= {WIDTH{1'b0}};
      bcd_err     <= 1'b0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], csn};
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_csn_d     <= w_csn_s;
      r_sck_d     <= w_sck_s;
      r_state     <= w_state_nx;
      // The reset-time ones must drain from the csn pipe before csn counts as high
      if ((r_state == ST_ARM) && w_csn_s) begin
        r_arm_cnt <= (r_arm_cnt == 2'(SYNC_STAGES)) ? r_arm_cnt : r_arm_cnt + 2'd1;
      end else begin
        r_arm_cnt <= 2'd0;
      end
      if ((r_state == ST_IDLE) && w_csn_fall) begin
        r_cnt   <= {CW{1'b0}};
        r_shift <= {WIDTH{1'b0}};
      end else if (w_shift_en) begin
        r_shift <= w_shift_nx;
        r_cnt   <= (r_cnt == CW'(WIDTH)) ? r_cnt : r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        r_cnt   <= r_cnt;
        r_shift <= r_shift;
      end
      if (w_load) begin
        data    <= w_shift_nx;
        bcd_err <= f_bcd_err(w_shift_nx);
      end else begin
        data    <= data;
        bcd_err <= bcd_err;
      end
      if (r_state != ST_HOLD) begin
        r_ovf <= 1'b0;
      end else if (w_csn_rise) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf | w_ovf_set;
      end
      r_valid_d <= w_load;
      r_ferr_d  <= w_ferr_evt;
      valid     <= r_valid_d;
      frame_err <= r_ferr_d & ~r_valid_d;
    end
  end

  // Next-state logic; a csn rise always beats a coincident sck rise
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_ARM: begin
        if (w_csn_s && (r_arm_cnt == 2'(SYNC_STAGES))) w_state_nx = ST_IDLE;
        else                                           w_state_nx = ST_ARM;
      end
      ST_IDLE: begin
        if (w_csn_fall) w_state_nx = ST_SHIFT;
        else            w_state_nx = ST_IDLE;
      end
      ST_SHIFT: begin
        if (w_csn_rise)                                     w_state_nx = ST_IDLE;
        else if (w_sck_rise && (r_cnt == CW'(WIDTH - 1)))   w_state_nx = ST_HOLD;
        else                                                w_state_nx = ST_SHIFT;
      end
      ST_HOLD: begin
        if (w_csn_rise) w_state_nx = ST_IDLE;
        else            w_state_nx = ST_HOLD;
      end
      default: w_state_nx = ST_ARM;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    w_shift_en = 1'b0;
    w_load     = 1'b0;
    w_ferr_evt = 1'b0;
    w_ovf_set  = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        w_shift_en = w_sck_rise & ~w_csn_rise;
        w_load     = w_sck_rise & ~w_csn_rise & (r_cnt == CW'(WIDTH - 1));
        w_ferr_evt = w_csn_rise & (r_cnt != {CW{1'b0}});
      end
      ST_HOLD: begin
        w_ovf_set  = w_sck_rise & ~w_csn_rise;
        w_ferr_evt = w_csn_rise & r_ovf;
      end
      default: begin
        w_shift_en = 1'b0;
        w_load     = 1'b0;
        w_ferr_evt = 1'b0;
        w_ovf_set  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_word_rx.sv
// Directed plus randomized bench for spi_word_rx; expectations come from a
// frame-level model (bits sent, word boundaries, nibble arithmetic).
module tb_spi_word_rx;
  localparam int WIDTH = 32;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             csn = 1'b1;
  logic             sck = 1'b0;
  logic             mosi = 1'b0;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             bcd_err;
  logic             frame_err;
  logic             busy;

  spi_word_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .csn(csn), .sck(sck), .mosi(mosi),
    .data(data), .valid(valid), .bcd_err(bcd_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed pulse history, written only by the monitor
  logic [WIDTH-1:0] vdata_q[$];
  int               vcyc_q[$];
  int               ferr_tot = 0;
  int               both_tot = 0;

  always @(negedge clk) begin
    if (valid) begin
      vdata_q.push_back(data);
      vcyc_q.push_back(cyc);
    end
    if (frame_err) ferr_tot <= ferr_tot + 1;
    if (valid && frame_err) both_tot <= both_tot + 1;
  end

  // Model state, written only by the stimulus thread
  logic [WIDTH-1:0] exp_data_q[$];
  int               exp_cyc_q[$];
  logic [WIDTH-1:0] exp_data = '0;
  logic             exp_bcd = 1'b0;
  int               exp_ferr = 0;
  int               v_rd = 0;
  int               ferr_base = 0;
  int               n_chk = 0;
  int               n_fail = 0;

  function automatic logic bcd_bad(input logic [WIDTH-1:0] w);
    longint unsigned v = longint'(w);
    for (int i = 0; i < WIDTH / 4; i++) begin
      if ((v % 16) > 9) return 1'b1;
      v = v / 16;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int half, input logic is_last_word_bit,
                          input logic [WIDTH-1:0] w);
    mosi = b;
    repeat (half) @(negedge clk);
    sck = 1'b1;
    if (is_last_word_bit) begin
      // The next posedge samples the final sck high; valid follows SYNC_STAGES+2 cycles later
      exp_cyc_q.push_back(cyc + 1 + SYNC_STAGES + 1);
      exp_data_q.push_back(w);
      exp_data = w;
      exp_bcd  = bcd_bad(w);
    end
    repeat (half) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic frame(input logic [WIDTH-1:0] w, input int n, input int half, input int gap);
    csn = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_open", busy, 1);
    for (int k = 0; k < n; k++) begin
      send_bit((k < WIDTH) ? w[WIDTH-1-k] : 1'($urandom_range(0, 1)), half, k == WIDTH - 1, w);
    end
    repeat (half) @(negedge clk);
    csn = 1'b1;
    if (n != WIDTH && n != 0) exp_ferr++;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    int nv;
    nv = vdata_q.size() - v_rd;
    chk({tag, "_nvalid"}, nv, exp_data_q.size());
    for (int i = 0; i < nv && i < exp_data_q.size(); i++) begin
      chk({tag, "_vdata"}, vdata_q[v_rd + i], exp_data_q[i]);
      chk({tag, "_latency"}, vcyc_q[v_rd + i], exp_cyc_q[i]);
    end
    chk({tag, "_nferr"}, ferr_tot - ferr_base, exp_ferr);
    chk({tag, "_data"}, data, exp_data);
    chk({tag, "_bcd"}, bcd_err, exp_bcd);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overlap"}, both_tot, 0);
    v_rd      = vdata_q.size();
    ferr_base = ferr_tot;
    exp_ferr  = 0;
    exp_data_q.delete();
    exp_cyc_q.delete();
  endtask

  initial begin
    int lens[6];
    logic [WIDTH-1:0] w;
    lens = '{8, 16, WIDTH, WIDTH, WIDTH + 1, WIDTH + 2};

    repeat (3) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_bcd", bcd_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    frame(32'h0000_0120, WIDTH, 4, 12);
    check_all("f0120");
    frame(32'h0000_004A, WIDTH, 5, 12);
    check_all("f004a");
    frame(32'h0000_0006, WIDTH, 4, 12);
    check_all("f0006");
    frame(32'hFFFF_1234, 16, 4, 12);
    check_all("abort16");
    frame(32'h0000_5040, WIDTH + 1, 4, 12);
    check_all("over33");

    // Reset after bit 10 with csn held low through the rest of the frame
    w = 32'h9876_5432;
    csn = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) send_bit(w[WIDTH-1-k], 4, 1'b0, w);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 10; k < WIDTH; k++) send_bit(w[WIDTH-1-k], 4, 1'b0, w);
    repeat (4) @(negedge clk);
    csn = 1'b1;
    exp_data = '0;
    exp_bcd  = 1'b0;
    repeat (12) @(negedge clk);
    check_all("midrst");
    frame(32'h0000_0024, WIDTH, 4, 12);
    check_all("f0024");

    // Back-to-back frames with a single clk cycle of csn high between them
    frame(32'h0000_0001, WIDTH, 4, 1);
    frame(32'h0000_0720, WIDTH, 4, 12);
    check_all("b2b");

    for (int r = 0; r < 8; r++) begin
      frame($urandom, lens[$urandom_range(0, 5)], $urandom_range(4, 6), 12);
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
